// File: rtl/sad_min_tracker_pkg.sv
// Shared parameters for the SAD minimum tracker: search-range constants,
// FSM state encoding and width helpers derived from block and pair counts.
package sad_min_tracker_pkg;

  localparam int SEARCH_RANGE_H = 8;
  localparam int SEARCH_RANGE_V = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // An 8-bit difference summed over blk_pix pixels needs log2(blk_pix) extra bits.
  function automatic int sad_width(input int blk_pix);
    return 8 + $clog2(blk_pix);
  endfunction

  function automatic int idx_width(input int num_pairs);
    return $clog2(2 * num_pairs);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sad_min_tracker_abs_diff8.sv
// Unsigned absolute difference of two 8-bit pixels.
module abs_diff8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] diff_o
);

  assign diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/sad_min_tracker.sv
// Accumulates SADs for an even/odd candidate pair per block pass and keeps the
// running minimum SAD and its candidate index across NUM_PAIRS passes.
module sad_min_tracker
  import sad_min_tracker_pkg::*;
#(
  parameter int BLK_PIX   = 64,
  parameter int NUM_PAIRS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [7:0]                          c,
  input  logic [7:0]                          p,
  input  logic [7:0]                          p_prime,
  output logic                                in_ready,
  output logic [sad_width(BLK_PIX)-1:0]       best_sad,
  output logic [idx_width(NUM_PAIRS)-1:0]     best_idx,
  output logic                                busy,
  output logic                                done,
  output state_e                              dbg_state_o
);

  localparam int SAD_W  = sad_width(BLK_PIX);
  localparam int IDX_W  = idx_width(NUM_PAIRS);
  localparam int PIX_W  = cnt_width(BLK_PIX);
  localparam int PAIR_W = cnt_width(NUM_PAIRS);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(BLK_PIX - 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

  state_e              state_q;
  logic [SAD_W-1:0]    acc0_q, acc1_q, best_sad_q;
  logic [IDX_W-1:0]    best_idx_q;
  logic [PIX_W-1:0]    pix_cnt_q;
  logic [PAIR_W-1:0]   pair_cnt_q;

  logic [7:0]          diff0, diff1;
  logic [SAD_W-1:0]    mid_sad_d, best_sad_d;
  logic [IDX_W-1:0]    mid_idx_d, best_idx_d;

  abs_diff8 u_diff_even (.a_i(c), .b_i(p),       .diff_o(diff0));
  abs_diff8 u_diff_odd  (.a_i(c), .b_i(p_prime), .diff_o(diff1));

  // Even candidate first, then odd against the updated best; strict < keeps
  // the lower index on ties.
  always_comb begin
    mid_sad_d  = best_sad_q;
    mid_idx_d  = best_idx_q;
    if (acc0_q < best_sad_q) begin
      mid_sad_d = acc0_q;
      mid_idx_d = IDX_W'({pair_cnt_q, 1'b0});
    end
    best_sad_d = mid_sad_d;
    best_idx_d = mid_idx_d;
    if (acc1_q < mid_sad_d) begin
      best_sad_d = acc1_q;
      best_idx_d = IDX_W'({pair_cnt_q, 1'b1});
    end
  end

  // Handshake: a triple is consumed on a rising edge where in_valid and
  // in_ready are both high; in_ready is decoded from state alone (ACCUM only).
  assign in_ready    = (state_q == ACCUM);
  assign busy        = (state_q == ACCUM) || (state_q == COMPARE);
  assign done        = (state_q == DONE);
  assign best_sad    = best_sad_q;
  assign best_idx    = best_idx_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc0_q     <= '0;
      acc1_q     <= '0;
      pix_cnt_q  <= '0;
      pair_cnt_q <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc0_q     <= '0;
            acc1_q     <= '0;
            pix_cnt_q  <= '0;
            pair_cnt_q <= '0;
            best_sad_q <= '1;
            best_idx_q <= '0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc0_q    <= acc0_q + SAD_W'(diff0);
            acc1_q    <= acc1_q + SAD_W'(diff1);
            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
            if (pix_cnt_q == LAST_PIX) state_q <= COMPARE;
          end
        end
        COMPARE: begin
          best_sad_q <= best_sad_d;
          best_idx_q <= best_idx_d;
          if (pair_cnt_q == LAST_PAIR) begin
            state_q <= DONE;
          end else begin
            pair_cnt_q <= pair_cnt_q + PAIR_W'(1);
            acc0_q     <= '0;
            acc1_q     <= '0;
            pix_cnt_q  <= '0;
            state_q    <= ACCUM;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker: uniform-pixel vector table, hand-built corner
// searches, and random searches scored against a plain-arithmetic SAD model.
module tb_sad_min_tracker;
  import sad_min_tracker_pkg::*;

  localparam int BLK_PIX   = 64;
  localparam int NUM_PAIRS = 8;
  localparam int TOTAL     = BLK_PIX * NUM_PAIRS;
  localparam int SAD_W     = 8 + $clog2(BLK_PIX);
  localparam int IDX_W     = $clog2(2 * NUM_PAIRS);
  localparam int BUDGET    = 20000;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        c, p, p_prime;
  logic              in_ready, busy, done;
  logic [SAD_W-1:0]  best_sad;
  logic [IDX_W-1:0]  best_idx;
  state_e            dbg_state;

  sad_min_tracker #(.BLK_PIX(BLK_PIX), .NUM_PAIRS(NUM_PAIRS)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .c(c), .p(p), .p_prime(p_prime), .in_ready(in_ready),
    .best_sad(best_sad), .best_idx(best_idx), .busy(busy), .done(done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- pixel store + reference model ----------------
  logic [7:0] arr_c[TOTAL];
  logic [7:0] arr_p[TOTAL];
  logic [7:0] arr_pp[TOTAL];

  task automatic fill_const(input int cv, input int pv, input int ppv);
    for (int i = 0; i < TOTAL; i++) begin
      arr_c[i] = 8'(cv); arr_p[i] = 8'(pv); arr_pp[i] = 8'(ppv);
    end
  endtask

  task automatic fill_random(input int span);
    for (int i = 0; i < TOTAL; i++) begin
      arr_c[i]  = 8'($urandom_range(span, 0));
      arr_p[i]  = 8'($urandom_range(span, 0));
      arr_pp[i] = 8'($urandom_range(span, 0));
    end
  endtask

  // Candidate k uses pair k/2 with p (even k) or p_prime (odd k); the first
  // candidate reaching the smallest SAD wins.
  task automatic model(output int sad, output int idx);
    sad = 32'h7fffffff;
    idx = 0;
    for (int k = 0; k < 2 * NUM_PAIRS; k++) begin
      int s;
      s = 0;
      for (int i = 0; i < BLK_PIX; i++) begin
        int a, b;
        a = arr_c[(k / 2) * BLK_PIX + i];
        b = (k % 2 == 0) ? arr_p[(k / 2) * BLK_PIX + i] : arr_pp[(k / 2) * BLK_PIX + i];
        s += (a > b) ? (a - b) : (b - a);
      end
      if (s < sad) begin
        sad = s;
        idx = k;
      end
    end
  endtask

  // ---------------- driver ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic run_search(input string tag, input int gap, input int mid_start_at,
                            input int abort_at);
    int consumed, cyc, early_done;
    logic v, rdy, mid_done;
    logic [31:0] es, ei;
    consumed = 0; cyc = 0; early_done = 0; mid_done = 1'b0;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " in_ready_after_start"}, int'(in_ready), 1);
    while (consumed < TOTAL && cyc < BUDGET && !(abort_at >= 0 && consumed == abort_at)) begin
      rdy = in_ready;
      v   = ($urandom_range(99, 0) >= gap);
      if (v && rdy) begin
        c = arr_c[consumed]; p = arr_p[consumed]; p_prime = arr_pp[consumed];
      end else begin
        c = 8'($urandom); p = 8'($urandom); p_prime = 8'($urandom);
      end
      in_valid = v;
      if (!mid_done && mid_start_at >= 0 && consumed >= mid_start_at) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) early_done++;
      if (v && rdy) consumed++;
      cyc++;
    end
    check({tag, " no_done_during_feed"}, early_done, 0);
    if (abort_at >= 0 && consumed == abort_at) return;
    check({tag, " feed_complete"}, consumed, TOTAL);
    if (consumed != TOTAL) return;
    // Garbage offered while not ready must be ignored.
    in_valid = 1'b1; c = 8'($urandom); p = 8'($urandom); p_prime = 8'($urandom);
    check({tag, " done_low_in_compare"}, int'(done), 0);
    check({tag, " busy_in_compare"}, int'(busy), 1);
    @(posedge clk); #1;
    es = exp_q.pop_front();
    ei = exp_q.pop_front();
    check({tag, " done_2_cycles_after_last"}, int'(done), 1);
    check({tag, " busy_low_in_done"}, int'(busy), 0);
    check({tag, " best_sad"}, int'(best_sad), int'(es));
    check({tag, " best_idx"}, int'(best_idx), int'(ei));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " best_sad_held"}, int'(best_sad), int'(es));
    check({tag, " in_ready_low_idle"}, int'(in_ready), 0);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] cv, pv, ppv;
    int         exp_sad;
    int         exp_idx;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int ms, mi, g_sad, g_idx, dones;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; c = '0; p = '0; p_prime = '0;

    // Uniform blocks: every pair gives 64*|c-p| and 64*|c-p'|.
    tbl[0] = '{8'd50,  8'd50,  8'd50,  0,     0};
    tbl[1] = '{8'd10,  8'd20,  8'd13,  192,   1};
    tbl[2] = '{8'd200, 8'd100, 8'd100, 6400,  0};
    tbl[3] = '{8'd0,   8'd255, 8'd0,   0,     1};
    tbl[4] = '{8'd255, 8'd0,   8'd0,   16320, 0};
    tbl[5] = '{8'd7,   8'd3,   8'd12,  256,   0};

    // Reset held 3 cycles, start asserted alongside it must lose.
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("reset best_sad", int'(best_sad), 0);
    check("reset best_idx", int'(best_idx), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset in_ready", int'(in_ready), 0);
    check("reset state_idle", int'(dbg_state == IDLE), 1);
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      fill_const(tbl[t].cv, tbl[t].pv, tbl[t].ppv);
      exp_q.push_back(32'(tbl[t].exp_sad));
      exp_q.push_back(32'(tbl[t].exp_idx));
      run_search($sformatf("vec%0d", t), 0, -1, -1);
    end

    // Only pair 5 matches exactly, worst case elsewhere.
    fill_const(0, 255, 255);
    for (int i = 5 * BLK_PIX; i < 6 * BLK_PIX; i++) arr_p[i] = 8'd0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd10);
    run_search("pair5_exact", 0, -1, -1);

    // Random data: gapless, then same data with 50% in_valid and a stray start.
    for (int r = 0; r < 3; r++) begin
      fill_random((r == 0) ? 3 : 255);
      model(ms, mi);
      exp_q.push_back(32'(ms));
      exp_q.push_back(32'(mi));
      run_search($sformatf("rand%0d_gapless", r), 0, -1, -1);
      g_sad = int'(best_sad);
      g_idx = int'(best_idx);
      exp_q.push_back(32'(ms));
      exp_q.push_back(32'(mi));
      run_search($sformatf("rand%0d_gaps", r), 50, 100 + 50 * r, -1);
      check($sformatf("rand%0d gaps_match_gapless_sad", r), int'(best_sad), g_sad);
      check($sformatf("rand%0d gaps_match_gapless_idx", r), int'(best_idx), g_idx);
    end

    // Reset at pix_cnt=30 of pair 2 abandons the search.
    fill_random(255);
    run_search("abort", 0, -1, 2 * BLK_PIX + 30);
    reset = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("abort state_idle", int'(dbg_state == IDLE), 1);
    check("abort busy", int'(busy), 0);
    check("abort in_ready", int'(in_ready), 0);
    check("abort best_sad", int'(best_sad), 0);
    check("abort best_idx", int'(best_idx), 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("abort no_done", dones, 0);
    model(ms, mi);
    exp_q.push_back(32'(ms));
    exp_q.push_back(32'(mi));
    run_search("after_abort", 30, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
